// File: rtl/ecdsa_wr_arbiter_if.sv
// Requester-side and write-side stream bundle for the result-FIFO write arbiter.
// master = arbiter view, slave = requesters plus FIFO write port view.
interface ecdsa_wr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 128
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ*WIDTH-1:0] s_tdata;
   logic [N_REQ-1:0]       s_tvalid;
   logic [N_REQ-1:0]       s_tlast;
   logic [N_REQ-1:0]       s_tready;

   logic [WIDTH-1:0]       m_tdata;
   logic [ID_W-1:0]        m_tid;
   logic                   m_tlast;
   logic                   m_tvalid;
   logic                   m_tready;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tid, m_tlast, m_tvalid
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tid, m_tlast, m_tvalid
   );
endinterface

// File: rtl/ecdsa_wr_arbiter.sv
// Round-robin packet-locked N:1 stream merge; grant 1 cycle after request, data accept->output 1 cycle.
// Backpressure: granted s_tready follows ~m_tvalid | m_tready; m_* hold while stalled; watchdog releases at MAX_BEATS.
module ecdsa_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 128,
   parameter int MAX_BEATS = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ecdsa_wr_arbiter_if.master         bus,
   output logic                       grant_valid,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       err_overrun
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
   localparam logic [ID_W:0]    N_EXT   = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic             out_en;
   logic             accept;
   logic             sel_vld;
   logic             sel_last;
   logic [WIDTH-1:0] sel_dat;
   logic [CNT_W-1:0] cnt_next;
   logic [ID_W-1:0]  next_ptr;
   logic             win_found;
   logic [ID_W-1:0]  win_id;
   logic [ID_W:0]    rr_sum;

   assign out_en   = ~bus.m_tvalid | bus.m_tready;
   assign sel_vld  = bus.s_tvalid[grant_id];
   assign sel_last = bus.s_tlast[grant_id];
   assign sel_dat  = bus.s_tdata[int'(grant_id)*WIDTH +: WIDTH];
   assign accept   = (state == LOCKED) & sel_vld & out_en;
   assign cnt_next = beat_cnt + CNT_W'(1);
   assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

   always_comb begin
      bus.s_tready = '0;
      if (state == LOCKED) begin
         bus.s_tready[grant_id] = out_en;
      end
   end

   // Scan from ptr upward with wrap; first valid requester wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      rr_sum    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rr_sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (rr_sum >= N_EXT) begin
            rr_sum = rr_sum - N_EXT;
         end
         if (!win_found && bus.s_tvalid[rr_sum[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = rr_sum[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         beat_cnt     <= '0;
         grant_valid  <= 1'b0;
         grant_id     <= '0;
         err_overrun  <= 1'b0;
         bus.m_tdata  <= '0;
         bus.m_tid    <= '0;
         bus.m_tlast  <= 1'b0;
         bus.m_tvalid <= 1'b0;
      end else begin
         err_overrun <= 1'b0;

         if (out_en) begin
            if (accept) begin
               bus.m_tdata  <= sel_dat;
               bus.m_tlast  <= sel_last;
               bus.m_tid    <= grant_id;
               bus.m_tvalid <= 1'b1;
            end else begin
               bus.m_tvalid <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= LOCKED;
                  grant_valid <= 1'b1;
                  grant_id    <= win_id;
                  beat_cnt    <= '0;
               end
            end
            LOCKED: begin
               if (accept) begin
                  beat_cnt <= cnt_next;
                  // tlast takes precedence over the watchdog: no error on a legal last beat.
                  if (sel_last || (cnt_next == MAX_CNT)) begin
                     state       <= IDLE;
                     grant_valid <= 1'b0;
                     ptr         <= next_ptr;
                     err_overrun <= ~sel_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
